float_result_pack: RTL and testbench

FLOAT_RESULT_PACK -- requirements
Module: float_result_pack

---
 rtl/float_result_pack_if.sv | 33 +++
 rtl/float_result_pack.sv | 141 ++++++++++++++
 tb/tb_float_result_pack.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/float_result_pack_if.sv
// float_result_pack_if
//   Bundles the rounding-stage handshake, the packed IEEE-754 result and the
//   downstream ready/valid pair for float_result_pack.
//   Parameters: n   mantissa width including hidden bit
//               exp exponent width
//   slave  modport: the packer (receives operand, drives result)
//   master modport: the environment (drives operand, consumes result)
interface float_result_pack_if #(
  parameter int n   = 24,
  parameter int exp = 8
);
  logic [n-1:0]     roundMant;
  logic [exp-1:0]   roundExp;
  logic             roundSign;
  logic             roundValid;
  logic             outputInvalid;
  logic             ResultValid;
  logic [exp+n-1:0] packedResult;
  logic             packValid;
  logic             packReady;
  logic             overflowFlag;
  logic             invalidFlag;

  modport slave (
    input  roundMant, roundExp, roundSign, roundValid, outputInvalid, packReady,
    output ResultValid, packedResult, packValid, overflowFlag, invalidFlag
  );

  modport master (
    output roundMant, roundExp, roundSign, roundValid, outputInvalid, packReady,
    input  ResultValid, packedResult, packValid, overflowFlag, invalidFlag
  );
endinterface

// File: rtl/float_result_pack.sv
// float_result_pack
//   Final stage of the FP pipeline: captures a rounded operand, packs it into
//   an IEEE-754 word {sign, exponent, fraction} handling NaN, signed zero,
//   round-up carry and overflow to infinity, then holds it on a valid/ready
//   interface until the consumer accepts it.
//   Ports:
//     Clock        single clock, rising edge
//     Reset        synchronous, active-high
//     bus          float_result_pack_if.slave (operand in, packed result out)
//     statusClear  (FLOAT_PACK_STATUS_EN only) clears the sticky status
//     packStatus   (FLOAT_PACK_STATUS_EN only) sticky {invalid, overflow, zero}
//   Optional feature macro: FLOAT_PACK_STATUS_EN
module float_result_pack #(
  parameter int n   = 24,
  parameter int exp = 8
) (
  input  logic Clock,
  input  logic Reset,
  float_result_pack_if.slave bus
`ifdef FLOAT_PACK_STATUS_EN
  ,
  input  logic       statusClear,
  output logic [2:0] packStatus
`endif
);

  typedef enum logic [1:0] {IDLE, PACK, HOLD} state_t;

  typedef struct packed {
    logic [exp+n-1:0] word;
    logic             ovf;
    logic             inv;
    logic             zero;
  } pack_t;

  state_t state, state_nxt;

  logic [n-1:0]   mant_p0;
  logic [exp-1:0] exp_p0;
  logic           sign_p0;
  logic           inv_p0;
  pack_t          res_p1;

  // Priority: invalid -> NaN, zero, carry wrap, overflow, normal packing.
  // The exponent is widened by one bit so 0xFF + carry cannot wrap to 0.
  function automatic pack_t pack_word(input logic [n-1:0] m, input logic [exp-1:0] e,
                                      input logic s, input logic inv);
    logic [exp:0] e_adj;
    logic [n-2:0] fr;
    pack_t        r;
    r     = '0;
    e_adj = {1'b0, e};
    fr    = m[n-2:0];
    if (inv) begin
      r.word = {1'b0, {exp{1'b1}}, 1'b1, {(n-2){1'b0}}};
      r.inv  = 1'b1;
    end else if (m == '0 && e == '0) begin
      r.word = {s, {(exp+n-1){1'b0}}};
      r.zero = 1'b1;
    end else begin
      // Hidden bit cleared on a non-zero exponent means rounding carried out.
      if (!m[n-1] && e != '0) begin
        e_adj = {1'b0, e} + {{exp{1'b0}}, 1'b1};
        fr    = '0;
      end
      if (e_adj >= {1'b0, {exp{1'b1}}}) begin
        r.word = {s, {exp{1'b1}}, {(n-1){1'b0}}};
        r.ovf  = 1'b1;
      end else begin
        r.word = {s, e_adj[exp-1:0], fr};
      end
    end
    return r;
  endfunction

  assign res_p1 = pack_word(mant_p0, exp_p0, sign_p0, inv_p0);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.roundValid) state_nxt = PACK;
      PACK:    state_nxt = HOLD;
      HOLD:    if (bus.packReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture from the rounding stage
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mant_p0         <= '0;
      exp_p0          <= '0;
      sign_p0         <= 1'b0;
      inv_p0          <= 1'b0;
      bus.ResultValid <= 1'b0;
    end else begin
      bus.ResultValid <= (state == IDLE) && bus.roundValid;
      if (state == IDLE && bus.roundValid) begin
        mant_p0 <= bus.roundMant;
        exp_p0  <= bus.roundExp;
        sign_p0 <= bus.roundSign;
        inv_p0  <= bus.outputInvalid;
      end
    end
  end

  // Stage p1: packed result registered at the close of PACK, held through HOLD
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.packedResult <= '0;
      bus.overflowFlag <= 1'b0;
      bus.invalidFlag  <= 1'b0;
      bus.packValid    <= 1'b0;
    end else if (state == PACK) begin
      bus.packedResult <= res_p1.word;
      bus.overflowFlag <= res_p1.ovf;
      bus.invalidFlag  <= res_p1.inv;
      bus.packValid    <= 1'b1;
    end else if (state == HOLD && bus.packReady) begin
      bus.packValid    <= 1'b0;
    end
  end

`ifdef FLOAT_PACK_STATUS_EN
  // Sticky status: bits set by a closing PACK survive a simultaneous clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      packStatus <= 3'b000;
    end else begin
      packStatus <= (statusClear ? 3'b000 : packStatus)
                  | ((state == PACK) ? {res_p1.inv, res_p1.ovf, res_p1.zero} : 3'b000);
    end
  end
`endif

endmodule

// File: tb/tb_float_result_pack.sv
module tb_float_result_pack;
  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] sts_m = 3'b000;

  float_result_pack_if #(.n(24), .exp(8)) bus ();

`ifdef FLOAT_PACK_STATUS_EN
  logic       statusClear;
  logic [2:0] packStatus;
  float_result_pack #(.n(24), .exp(8)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .statusClear(statusClear), .packStatus(packStatus));
`else
  float_result_pack #(.n(24), .exp(8)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus));
`endif

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: {inv, ovf, zero, word} from the IEEE packing rules, using integers.
  function automatic logic [34:0] model(input logic [23:0] m, input logic [7:0] e,
                                        input logic s, input logic inv);
    int          ee;
    logic [22:0] fr;
    if (inv) return {3'b100, 32'h7FC0_0000};
    if (m == 0 && e == 0) return {3'b001, s, 31'd0};
    ee = int'(e);
    fr = m[22:0];
    if (m[23] == 1'b0 && e != 0) begin
      ee = ee + 1;
      fr = 23'd0;
    end
    if (ee >= 255) return {3'b010, s, 8'hFF, 23'd0};
    return {3'b000, s, ee[7:0], fr};
  endfunction

  task automatic chk_status(input string tag);
`ifdef FLOAT_PACK_STATUS_EN
    chk(tag, {61'd0, packStatus}, {61'd0, sts_m});
`else
    chk(tag, {63'd0, bus.packValid}, {63'd0, bus.packValid & 1'b1});
`endif
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    sts_m = 3'b000;
  endtask

  // Entered just after a negedge; leaves the DUT back in IDLE after a negedge.
  task automatic run_op(input logic [23:0] m, input logic [7:0] e, input logic s,
                        input logic inv, input int hold);
    logic [34:0] want;
    want = model(m, e, s, inv);
    bus.roundMant = m; bus.roundExp = e; bus.roundSign = s;
    bus.outputInvalid = inv; bus.roundValid = 1'b1; bus.packReady = 1'b0;
    @(negedge Clock);
    bus.roundValid = 1'b0;
    bus.roundMant = 24'($urandom); bus.roundExp = 8'($urandom);
    bus.outputInvalid = 1'($urandom);
    chk("rv_pulse", {63'd0, bus.ResultValid}, 64'd1);
    chk("pv_early", {63'd0, bus.packValid}, 64'd0);
    @(negedge Clock);
    sts_m = sts_m | want[34:32];
    chk("rv_clear", {63'd0, bus.ResultValid}, 64'd0);
    chk("pv_set", {63'd0, bus.packValid}, 64'd1);
    chk("word", {32'd0, bus.packedResult}, {32'd0, want[31:0]});
    chk("flags", {62'd0, bus.invalidFlag, bus.overflowFlag}, {62'd0, want[34:33]});
    chk_status("status");
    for (int i = 0; i < hold; i++) begin
      bus.roundValid = (i % 2 == 0);
      bus.roundMant = 24'($urandom);
      @(negedge Clock);
      chk("hold_word", {32'd0, bus.packedResult}, {32'd0, want[31:0]});
      chk("hold_rv", {63'd0, bus.ResultValid}, 64'd0);
      chk("hold_pv", {63'd0, bus.packValid}, 64'd1);
    end
    bus.roundValid = 1'b0;
    bus.packReady = 1'b1;
    @(negedge Clock);
    bus.packReady = 1'b0;
    chk("pv_drop", {63'd0, bus.packValid}, 64'd0);
  endtask

  initial begin
    logic [23:0] rm;
    logic [7:0]  re;
    bus.roundMant = '0; bus.roundExp = '0; bus.roundSign = 1'b0;
    bus.roundValid = 1'b0; bus.outputInvalid = 1'b0; bus.packReady = 1'b0;
`ifdef FLOAT_PACK_STATUS_EN
    statusClear = 1'b0;
`endif
    Reset = 1'b1;
    @(negedge Clock);
    do_reset();
    chk("rst_pv", {63'd0, bus.packValid}, 64'd0);
    chk("rst_rv", {63'd0, bus.ResultValid}, 64'd0);
    chk("rst_word", {32'd0, bus.packedResult}, 64'd0);
    chk("rst_flags", {62'd0, bus.invalidFlag, bus.overflowFlag}, 64'd0);
    chk_status("rst_status");

    // Directed operands, then a long HOLD with a second operand re-presented afterwards.
    run_op(24'hC00000, 8'h80, 1'b0, 1'b0, 0);
    chk("req034", {32'd0, bus.packedResult}, 64'h4040_0000);
    run_op(24'h800001, 8'h10, 1'b1, 1'b0, 10);
    run_op(24'hA00000, 8'h81, 1'b0, 1'b0, 0);

    // packReady while nothing is valid does nothing.
    bus.packReady = 1'b1;
    repeat (3) @(negedge Clock);
    bus.packReady = 1'b0;
    chk("idle_ready", {63'd0, bus.packValid}, 64'd0);

    // Reset while holding a result.
    bus.roundMant = 24'hC00000; bus.roundExp = 8'h80; bus.roundValid = 1'b1;
    @(negedge Clock);
    bus.roundValid = 1'b0;
    @(negedge Clock);
    do_reset();
    chk("rst_hold_pv", {63'd0, bus.packValid}, 64'd0);
    chk("rst_hold_word", {32'd0, bus.packedResult}, 64'd0);
    chk_status("rst_hold_status");

    // Sticky status accumulates over the three special results.
    run_op(24'h000000, 8'h7F, 1'b1, 1'b0, 1);
    chk("req035", {32'd0, bus.packedResult}, 64'hC000_0000);
    run_op(24'h000000, 8'hFE, 1'b0, 1'b0, 0);
    chk("req036", {32'd0, bus.packedResult}, 64'h7F80_0000);
    chk("req036_ovf", {63'd0, bus.overflowFlag}, 64'd1);
    run_op(24'h123456, 8'h33, 1'b1, 1'b1, 0);
    chk("req037", {32'd0, bus.packedResult}, 64'h7FC0_0000);
    chk("req037_inv", {63'd0, bus.invalidFlag}, 64'd1);
`ifdef FLOAT_PACK_STATUS_EN
    statusClear = 1'b1;
    @(negedge Clock);
    statusClear = 1'b0;
    sts_m = 3'b000;
    chk_status("status_clear");
`endif

    // Reset during PACK discards the operand.
    bus.roundMant = 24'h000000; bus.roundExp = 8'hFF; bus.roundValid = 1'b1;
    @(negedge Clock);
    bus.roundValid = 1'b0;
    do_reset();
    chk("rst_pack_rv", {63'd0, bus.ResultValid}, 64'd0);
    @(negedge Clock);
    chk("rst_pack_pv", {63'd0, bus.packValid}, 64'd0);
    chk("rst_pack_flag", {63'd0, bus.overflowFlag}, 64'd0);

    // Zero exponent + carry boundary and the 0xFF input.
    run_op(24'h000000, 8'hFF, 1'b1, 1'b0, 0);
    run_op(24'h7FFFFF, 8'hFF, 1'b0, 1'b0, 0);
    run_op(24'h000000, 8'h00, 1'b1, 1'b0, 0);
    run_op(24'h400000, 8'h00, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      rm = 24'($urandom);
      re = 8'($urandom);
      case ($urandom_range(0, 5))
        0: re = 8'hFE;
        1: re = 8'hFF;
        2: begin re = 8'h00; rm = 24'd0; end
        3: rm[23] = 1'b0;
        default: rm[23] = 1'b1;
      endcase
      run_op(rm, re, 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
